zqh_test_status_ctrl: RTL and testbench
=======================================

# zqh_test_status_ctrl

Multi-channel test-status collector for the zqh_riscv verification SoC. It takes tohost-style result writes from up to N_CH harts or debug agents, tracks each enabled channel to completion, and applies an optional fail-fast policy and a cycle watchdog. It produces one registered verdict (done/pass/fail/timeout) for the bench's test selector, which reports and finishes on it. This is the parametrised successor to a single-test, single-result flow: channel count, data width, timeout and stop policy are all configurable.

## Interface
- N_CH, 4: number of result channels (1..16)
- DATA_W, 32: result word width (≥2)
- CNT_W, 32: cycle/timeout counter width
- STOP_ON_FAIL, 1: 1 = verdict on first failing finish; 0 = wait for all enabled channels
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; starts or restarts a run
- cfg_ch_en  in  N_CH  channel enable mask, sampled on start
- cfg_timeout  in  CNT_W  watchdog limit in cycles; 0 = disabled; sampled on start
- wr_valid  in  N_CH  per-channel write request
- wr_ready  out  N_CH  per-channel accept
- wr_data  in  N_CH*DATA_W  per-channel result word; channel i is at [i*DATA_W +: DATA_W]
- ch_done  out  N_CH  sticky per-channel finish seen
- done  out  1  verdict valid; sticky until the next start
- pass  out  1  all enabled channels finished with code 0
- fail  out  1  some enabled channel finished with a nonzero code
- timeout  out  1  watchdog expired
- fail_ch  out  $clog2(N_CH) (min 1)  index of the first failing channel
- fail_code  out  DATA_W-1  code of that failure (wr_data>>1)
- cycles  out  CNT_W  RUN cycles elapsed; saturates at max

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start → RUN. Entering RUN clears ch_done, cycles, the verdict, fail_ch and fail_code, and latches cfg_ch_en and cfg_timeout.
- RUN:
  - wr_ready[i] = 1 only for an enabled channel whose ch_done is 0. All other channels, and all channels in IDLE/DONE, get 0.
  - Accepted write with bit0 = 0 is a heartbeat: it is discarded and the watchdog keeps running.
  - Accepted write with bit0 = 1 is a finish: it sets ch_done[i]. Code = data>>1; nonzero means the channel failed.
  - The first failure latches fail_ch/fail_code. On simultaneous failures the lowest index wins. Later failures do not overwrite it.
- Exit RUN → DONE, evaluated in this priority order:
  1. a failure exists and STOP_ON_FAIL = 1 → fail
  2. all enabled channels are done → pass if there was no failure, else fail
  3. cfg_timeout ≠ 0 and cycles == cfg_timeout-1 → timeout
- Exactly one of pass/fail/timeout is set while done = 1.
- Enabled mask all-zero: RUN → DONE on the next cycle with pass = 1.
- start while in RUN restarts the run (same clear/latch as above); writes in that cycle are dropped.

## Timing
- Reset values: wr_ready = 0, ch_done = 0, done = pass = fail = timeout = 0, fail_ch = 0, fail_code = 0, cycles = 0. Async assert; deassert takes effect at the next clock edge.
- start at edge k → RUN and wr_ready visible from cycle k+1.
- Finish accepted at edge k → ch_done[i] = 1 after edge k; done/verdict = 1 after edge k+1 (one registered evaluation stage).
- cycles increments on every RUN clock edge, including the edge that exits to DONE.
- With cfg_timeout = T, done/timeout assert exactly T cycles after RUN entry, unless a pass/fail resolves first. A pass/fail resolving on the same edge as the timeout takes priority.
- Outputs are all registered; there are no combinational paths from input to output except wr_ready, which depends on state only.

## Structure
- zqh_test_status_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - finish-bit position and code-shift constants
  - verdict encoding
- Sub-module zqh_test_status_ch, instantiated N_CH times, holds one channel: ready logic, ch_done flop, finish/fail decode.
- The top holds the FSM, the lowest-index fail priority encoder, the cycle/watchdog counter and the verdict registers.

## Test plan
- N_CH=4, mask 4'b1111; finish writes 0x1 on ch0..3 in separate cycles → after the last one, done = pass = 1, fail = 0, ch_done = 4'hF.
- STOP_ON_FAIL=1; ch2 writes 0x7 → done = fail = 1 two edges later, fail_ch = 2, fail_code = 3; ch1 write afterwards sees wr_ready = 0.
- Same-cycle finish on ch1 = 0x5 and ch3 = 0x9 → fail_ch = 1, fail_code = 2.
- cfg_timeout = 100, ch0 sends only heartbeats (0x2) → done = timeout = 1 exactly 100 cycles after RUN entry, cycles = 100.
- Mask 4'b0101, STOP_ON_FAIL=0; ch0 finishes with fail 0x3 and later ch2 with pass 0x1 → verdict waits for ch2, then fail = 1, fail_ch = 0; writes on ch1/ch3 are never accepted.
- reset_n low mid-RUN → all outputs return to reset values immediately. start in DONE → verdict cleared and a new run completes normally.

Source files
------------

// File: rtl/zqh_test_status_pkg.sv
// Shared types and constants for the multi-channel test-status collector.
// Result words carry a finish flag in bit 0 and the result code in the bits above it.
package zqh_test_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        VD_NONE    = 2'd0,
        VD_PASS    = 2'd1,
        VD_FAIL    = 2'd2,
        VD_TIMEOUT = 2'd3
    } verdict_t;

    localparam int FINISH_BIT = 0;
    localparam int CODE_SHIFT = 1;

endpackage

// File: rtl/zqh_test_status_ctrl_if.sv
// Per-channel result-write bus: agents drive valid/data, the collector returns ready.
interface zqh_test_status_ctrl_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32
);
    logic [N_CH-1:0]        wr_valid;
    logic [N_CH-1:0]        wr_ready;
    logic [N_CH*DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/zqh_test_status_ch.sv
// One result channel: accepts writes while running and unfinished, records the
// finish flag and reports a failing finish in the cycle it is accepted.
module zqh_test_status_ch
    import zqh_test_status_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic              clear,
    input  logic              en,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              ch_done,
    output logic              fail_now,
    output logic [DATA_W-2:0] code
);

    logic accept;
    logic finish;

    assign ready    = run & en & ~ch_done;
    // a restart pulse drops any write presented in the same cycle
    assign accept   = ready & valid & ~clear;
    assign finish   = accept & data[FINISH_BIT];
    assign code     = data[DATA_W-1:CODE_SHIFT];
    assign fail_now = finish & (code != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ch_done <= 1'b0;
        end else if (clear) begin
            ch_done <= 1'b0;
        end else if (finish) begin
            ch_done <= 1'b1;
        end
    end

endmodule

// File: rtl/zqh_test_status_ctrl.sv
// Test-status collector top: run FSM, first-failure capture, cycle watchdog and
// registered verdict.
//   state   | meaning
//   IDLE    | after reset, no run started
//   RUN     | collecting results, cycle counter running
//   DONE    | verdict held until the next start
module zqh_test_status_ctrl
    import zqh_test_status_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 32,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic                                       start,
    input  logic [N_CH-1:0]                            cfg_ch_en,
    input  logic [CNT_W-1:0]                           cfg_timeout,
    zqh_test_status_ctrl_if.slave                      wr,
    output logic [N_CH-1:0]                            ch_done,
    output logic                                       done,
    output logic                                       pass,
    output logic                                       fail,
    output logic                                       timeout,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] fail_ch,
    output logic [DATA_W-2:0]                          fail_code,
    output logic [CNT_W-1:0]                           cycles
);

    localparam int FC_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state_q, state_d;
    verdict_t          verdict_q, verdict_d;
    logic [N_CH-1:0]   en_q;
    logic [CNT_W-1:0]  timeout_q;
    logic [CNT_W-1:0]  cycles_q;
    logic              fail_seen_q;
    logic [FC_W-1:0]   fail_ch_q;
    logic [DATA_W-2:0] fail_code_q;

    logic [N_CH-1:0]   ready;
    logic [N_CH-1:0]   fail_now;
    logic [DATA_W-2:0] code [N_CH];
    logic              run;
    logic              any_fail;
    logic              all_done;
    logic              wd_hit;
    logic [FC_W-1:0]   first_ch;
    logic [DATA_W-2:0] first_code;

    assign run = (state_q == ST_RUN);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        zqh_test_status_ch #(.DATA_W(DATA_W)) u_ch (
            .clock    (clock),
            .reset_n  (reset_n),
            .run      (run),
            .clear    (start),
            .en       (en_q[i]),
            .valid    (wr.wr_valid[i]),
            .data     (wr.wr_data[i*DATA_W +: DATA_W]),
            .ready    (ready[i]),
            .ch_done  (ch_done[i]),
            .fail_now (fail_now[i]),
            .code     (code[i])
        );
    end

    assign wr.wr_ready = ready;

    // scan downwards so the lowest failing index is the one left standing
    always_comb begin
        first_ch   = '0;
        first_code = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (fail_now[i]) begin
                first_ch   = FC_W'(i);
                first_code = code[i];
            end
        end
    end

    assign any_fail = |fail_now;
    assign all_done = ((ch_done & en_q) == en_q);
    assign wd_hit   = (timeout_q != '0) && (cycles_q == timeout_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    verdict_d = VD_NONE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    verdict_d = VD_NONE;
                end else if (fail_seen_q && STOP_ON_FAIL) begin
                    state_d   = ST_DONE;
                    verdict_d = VD_FAIL;
                end else if (all_done) begin
                    state_d   = ST_DONE;
                    verdict_d = fail_seen_q ? VD_FAIL : VD_PASS;
                end else if (wd_hit) begin
                    state_d   = ST_DONE;
                    verdict_d = VD_TIMEOUT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                verdict_d = VD_NONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            verdict_q <= VD_NONE;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q        <= '0;
            timeout_q   <= '0;
            cycles_q    <= '0;
            fail_seen_q <= 1'b0;
            fail_ch_q   <= '0;
            fail_code_q <= '0;
        end else if (start) begin
            en_q        <= cfg_ch_en;
            timeout_q   <= cfg_timeout;
            cycles_q    <= '0;
            fail_seen_q <= 1'b0;
            fail_ch_q   <= '0;
            fail_code_q <= '0;
        end else if (run) begin
            if (cycles_q != '1) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (any_fail && !fail_seen_q) begin
                fail_seen_q <= 1'b1;
                fail_ch_q   <= first_ch;
                fail_code_q <= first_code;
            end
        end
    end

    assign done      = (state_q == ST_DONE);
    assign pass      = (verdict_q == VD_PASS);
    assign fail      = (verdict_q == VD_FAIL);
    assign timeout   = (verdict_q == VD_TIMEOUT);
    assign fail_ch   = fail_ch_q;
    assign fail_code = fail_code_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_zqh_test_status_ctrl.sv
// Drives identical result traffic into a fail-fast and a wait-for-all collector and
// checks both against an event-level model of when and how each run resolves.
module tb_zqh_test_status_ctrl;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int CW   = 32;
    localparam int MAXL = 128;
    localparam int BND  = 200;
    localparam int INF  = 1000000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  cfg_ch_en = '0;
    logic [CW-1:0] cfg_timeout = '0;

    zqh_test_status_ctrl_if #(.N_CH(N), .DATA_W(DW)) bus_sf ();
    zqh_test_status_ctrl_if #(.N_CH(N), .DATA_W(DW)) bus_nf ();

    logic [N-1:0]  ch_done_sf, ch_done_nf;
    logic          done_sf, pass_sf, fail_sf, timeout_sf;
    logic          done_nf, pass_nf, fail_nf, timeout_nf;
    logic [1:0]    fail_ch_sf, fail_ch_nf;
    logic [DW-2:0] fail_code_sf, fail_code_nf;
    logic [CW-1:0] cycles_sf, cycles_nf;

    zqh_test_status_ctrl #(.N_CH(N), .DATA_W(DW), .CNT_W(CW), .STOP_ON_FAIL(1'b1)) dut_sf (
        .clock(clock), .reset_n(reset_n), .start(start), .cfg_ch_en(cfg_ch_en),
        .cfg_timeout(cfg_timeout), .wr(bus_sf), .ch_done(ch_done_sf), .done(done_sf),
        .pass(pass_sf), .fail(fail_sf), .timeout(timeout_sf), .fail_ch(fail_ch_sf),
        .fail_code(fail_code_sf), .cycles(cycles_sf));

    zqh_test_status_ctrl #(.N_CH(N), .DATA_W(DW), .CNT_W(CW), .STOP_ON_FAIL(1'b0)) dut_nf (
        .clock(clock), .reset_n(reset_n), .start(start), .cfg_ch_en(cfg_ch_en),
        .cfg_timeout(cfg_timeout), .wr(bus_nf), .ch_done(ch_done_nf), .done(done_nf),
        .pass(pass_nf), .fail(fail_nf), .timeout(timeout_nf), .fail_ch(fail_ch_nf),
        .fail_code(fail_code_nf), .cycles(cycles_nf));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // write schedule, indexed by cycle since RUN entry
    logic [N-1:0]  sch_v [MAXL];
    logic [DW-1:0] sch_d [MAXL][N];

    int            fin  [N];
    logic [DW-2:0] fcode [N];
    int            exp_x [2];
    int            exp_vd [2];
    logic [N-1:0]  exp_cd [2];
    int            exp_fch [2];
    logic [DW-2:0] exp_fc [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_sched();
        for (int j = 0; j < MAXL; j++) begin
            sch_v[j] = '0;
            for (int i = 0; i < N; i++) sch_d[j][i] = '0;
        end
    endtask

    task automatic put(input int j, input int ch, input logic [DW-1:0] d);
        sch_v[j][ch] = 1'b1;
        sch_d[j][ch] = d;
    endtask

    // first accepted finish per enabled channel, assuming the run were still open
    task automatic find_finishes(input logic [N-1:0] mask, input int len);
        for (int i = 0; i < N; i++) begin
            fin[i]   = -1;
            fcode[i] = '0;
            if (mask[i]) begin
                for (int j = 0; j < len; j++) begin
                    if (fin[i] < 0 && sch_v[j][i] && sch_d[j][i][0]) begin
                        fin[i]   = j;
                        fcode[i] = sch_d[j][i][DW-1:1];
                    end
                end
            end
        end
    endtask

    // exit edge: fail-fast at first failing finish + 2, all-done at last finish + 2
    // (edge 1 for an empty mask), watchdog at edge T; ties resolve in that order
    task automatic model(input int p, input logic [N-1:0] mask, input int t, input bit stop);
        int ff, ad, te, best;
        bit any_fail;
        ff = INF; ad = 1; te = (t != 0) ? t : INF; any_fail = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (fin[i] < 0) ad = INF;
                else if (ad != INF && fin[i] + 2 > ad) ad = fin[i] + 2;
                if (fin[i] >= 0 && fcode[i] != '0) begin
                    any_fail = 1;
                    if (fin[i] + 2 < ff) ff = fin[i] + 2;
                end
            end
        end
        if (stop && ff <= ad && ff <= te) begin
            exp_x[p] = ff; exp_vd[p] = 2;
        end else if (ad <= te) begin
            exp_x[p] = ad; exp_vd[p] = any_fail ? 2 : 1;
        end else begin
            exp_x[p] = te; exp_vd[p] = 3;
        end
        exp_cd[p] = '0; exp_fch[p] = 0; exp_fc[p] = '0; best = INF;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && fin[i] >= 0 && fin[i] + 1 <= exp_x[p]) begin
                exp_cd[p][i] = 1'b1;
                if (fcode[i] != '0 && fin[i] < best) begin
                    best = fin[i]; exp_fch[p] = i; exp_fc[p] = fcode[i];
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_ready(input int p, input logic [N-1:0] mask, input int j);
        logic [N-1:0] r;
        r = '0;
        if (j < exp_x[p]) begin
            for (int i = 0; i < N; i++) r[i] = mask[i] && !(fin[i] >= 0 && fin[i] < j);
        end
        return r;
    endfunction

    task automatic drive(input int j, input int len);
        for (int i = 0; i < N; i++) begin
            bus_sf.wr_valid[i]           = (j < len) ? sch_v[j][i] : 1'b0;
            bus_sf.wr_data[i*DW +: DW]   = (j < len) ? sch_d[j][i] : '0;
            bus_nf.wr_valid[i]           = (j < len) ? sch_v[j][i] : 1'b0;
            bus_nf.wr_data[i*DW +: DW]   = (j < len) ? sch_d[j][i] : '0;
        end
    endtask

    task automatic run_case(input string name, input logic [N-1:0] mask, input int t, input int len);
        int de_sf, de_nf;
        find_finishes(mask, len);
        model(0, mask, t, 1'b1);
        model(1, mask, t, 1'b0);
        @(negedge clock);
        start = 1'b1; cfg_ch_en = mask; cfg_timeout = CW'(t);
        drive(MAXL, 0);
        @(posedge clock); #1;
        start = 1'b0;
        de_sf = -1; de_nf = -1;
        for (int j = 0; j < BND && (de_sf < 0 || de_nf < 0); j++) begin
            chk({name, ".ready_sf"}, 64'(bus_sf.wr_ready), 64'(exp_ready(0, mask, j)));
            chk({name, ".ready_nf"}, 64'(bus_nf.wr_ready), 64'(exp_ready(1, mask, j)));
            drive(j, len);
            @(posedge clock); #1;
            if (done_sf && de_sf < 0) de_sf = j + 1;
            if (done_nf && de_nf < 0) de_nf = j + 1;
        end
        drive(MAXL, 0);
        chk({name, ".sf.done_edge"}, 64'(de_sf), 64'(exp_x[0]));
        chk({name, ".sf.verdict"}, {61'd0, pass_sf, fail_sf, timeout_sf},
            {61'd0, exp_vd[0] == 1, exp_vd[0] == 2, exp_vd[0] == 3});
        chk({name, ".sf.ch_done"}, 64'(ch_done_sf), 64'(exp_cd[0]));
        chk({name, ".sf.fail_ch"}, 64'(fail_ch_sf), 64'(exp_fch[0]));
        chk({name, ".sf.fail_code"}, 64'(fail_code_sf), 64'(exp_fc[0]));
        chk({name, ".sf.cycles"}, 64'(cycles_sf), 64'(exp_x[0]));
        chk({name, ".nf.done_edge"}, 64'(de_nf), 64'(exp_x[1]));
        chk({name, ".nf.verdict"}, {61'd0, pass_nf, fail_nf, timeout_nf},
            {61'd0, exp_vd[1] == 1, exp_vd[1] == 2, exp_vd[1] == 3});
        chk({name, ".nf.ch_done"}, 64'(ch_done_nf), 64'(exp_cd[1]));
        chk({name, ".nf.fail_ch"}, 64'(fail_ch_nf), 64'(exp_fch[1]));
        chk({name, ".nf.fail_code"}, 64'(fail_code_nf), 64'(exp_fc[1]));
        chk({name, ".nf.cycles"}, 64'(cycles_nf), 64'(exp_x[1]));
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, ".sf.status"},
            64'({bus_sf.wr_ready, ch_done_sf, done_sf, pass_sf, fail_sf, timeout_sf, fail_ch_sf}), 64'd0);
        chk({name, ".sf.code_cyc"}, {1'b0, fail_code_sf, cycles_sf}, 64'd0);
        chk({name, ".nf.status"},
            64'({bus_nf.wr_ready, ch_done_nf, done_nf, pass_nf, fail_nf, timeout_nf, fail_ch_nf}), 64'd0);
        chk({name, ".nf.code_cyc"}, {1'b0, fail_code_nf, cycles_nf}, 64'd0);
    endtask

    initial begin
        drive(MAXL, 0);
        #12;
        check_reset_vals("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_reset_vals("idle");

        // all four pass in separate cycles
        clear_sched();
        for (int i = 0; i < N; i++) put(i, i, 32'h1);
        run_case("all_pass", 4'hF, 0, 6);

        // ch2 fails; ch1 finishes later, after the fail-fast verdict
        clear_sched();
        put(2, 2, 32'h7); put(6, 1, 32'h1); put(8, 0, 32'h1); put(8, 3, 32'h1);
        run_case("fail_fast", 4'hF, 0, 10);

        // simultaneous failures, lowest index wins
        clear_sched();
        put(1, 1, 32'h5); put(1, 3, 32'h9); put(5, 0, 32'h1); put(5, 2, 32'h1);
        run_case("same_cycle", 4'hF, 0, 7);

        // heartbeats only until the watchdog fires
        clear_sched();
        for (int j = 0; j < 110; j++) put(j, 0, 32'h2);
        run_case("watchdog", 4'h1, 100, 110);

        // sparse mask; disabled channels never accepted
        clear_sched();
        put(1, 0, 32'h3); put(2, 1, 32'h1); put(3, 3, 32'h3); put(5, 2, 32'h1); put(7, 3, 32'h3);
        run_case("sparse_mask", 4'b0101, 0, 9);

        clear_sched();
        run_case("empty_mask", 4'h0, 0, 1);

        // restart while running drops the same-cycle write and clears progress
        @(negedge clock);
        start = 1'b1; cfg_ch_en = 4'hF; cfg_timeout = '0;
        @(posedge clock); #1;
        start = 1'b0;
        bus_sf.wr_valid = 4'b0001; bus_sf.wr_data = {96'd0, 32'h1};
        bus_nf.wr_valid = 4'b0001; bus_nf.wr_data = {96'd0, 32'h1};
        @(posedge clock); #1;
        chk("restart.pre_ch_done", 64'(ch_done_sf), 64'h1);
        bus_sf.wr_valid = 4'b0010; bus_sf.wr_data = {64'd0, 32'h1, 32'h0};
        bus_nf.wr_valid = 4'b0010; bus_nf.wr_data = {64'd0, 32'h1, 32'h0};
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        drive(MAXL, 0);
        chk("restart.ch_done", 64'({ch_done_sf, ch_done_nf}), 64'h0);
        chk("restart.cycles", 64'(cycles_sf), 64'h0);
        chk("restart.ready", 64'({bus_sf.wr_ready, done_sf}), 64'h1E);

        // asynchronous reset in the middle of a run
        @(posedge clock); #1;
        bus_sf.wr_valid = 4'b0001; bus_sf.wr_data = {96'd0, 32'h1};
        bus_nf.wr_valid = 4'b0001; bus_nf.wr_data = {96'd0, 32'h1};
        @(posedge clock); #1;
        drive(MAXL, 0);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clock);
        reset_n = 1'b1;

        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] mask;
            int t, len;
            logic [DW-1:0] d;
            clear_sched();
            mask = N'($urandom_range(0, 15));
            t    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            len  = $urandom_range(4, 30);
            for (int j = 0; j < len; j++) begin
                for (int i = 0; i < N; i++) begin
                    if (j == len - 1 || $urandom_range(0, 2) == 0) begin
                        d = $urandom();
                        if ($urandom_range(0, 1) == 0) d[DW-1:1] = '0;
                        d[0] = (j == len - 1) || ($urandom_range(0, 3) == 0);
                        put(j, i, d);
                    end
                end
            end
            run_case($sformatf("rand%0d", r), mask, t, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
